// File: rtl/dht11_read_scheduler.sv
// Round scheduler for up to four DHT11 sensors sharing one single-wire read
// engine. A round visits every channel of the mask latched at round start,
// retries failed reads, keeps the latest result per channel and flags the
// channels that could not be read.
module dht11_read_scheduler #(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned SETTLE_MS   = 1,
  parameter int unsigned TIMEOUT_MS  = 50,
  parameter int unsigned RETRY_MS    = 1000,
  parameter int unsigned MAX_RETRY   = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sw_req,
  input  logic        auto_en,
  input  logic [15:0] auto_period_ms,
  input  logic [3:0]  ch_mask,
  output logic        eng_start,
  input  logic        eng_done,
  input  logic        eng_chk_ok,
  input  logic [7:0]  eng_hum,
  input  logic [7:0]  eng_temp,
  output logic [1:0]  ch_sel,
  input  logic [1:0]  rd_ch,
  output logic [7:0]  rd_hum,
  output logic [7:0]  rd_temp,
  output logic        rd_valid,
  output logic        busy,
  output logic        round_done,
  output logic [3:0]  err_mask
);

  // Clocks per millisecond; a clock slower than 1 kHz degenerates to one tick per clock.
  localparam int unsigned TICK_DIV = (CLK_FREQ_HZ / 1000 > 0) ? CLK_FREQ_HZ / 1000 : 1;
  localparam int unsigned PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  // One shared millisecond counter serves SETTLE, WAIT_DONE and RETRY_WAIT.
  localparam int unsigned WAIT_MAX =
    (SETTLE_MS > TIMEOUT_MS) ? ((SETTLE_MS > RETRY_MS) ? SETTLE_MS : RETRY_MS)
                             : ((TIMEOUT_MS > RETRY_MS) ? TIMEOUT_MS : RETRY_MS);
  localparam int unsigned WW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {
    IDLE, PICK, SETTLE, START, WAIT_DONE, STORE, RETRY_WAIT, FINISH
  } state_t;

  state_t          state_q;
  logic [PW-1:0]   presc_cnt;
  logic            ms_tick;
  logic [15:0]     auto_cnt;
  logic [15:0]     period_eff;
  logic            auto_expire;
  logic            start_req;
  logic            pending_q;
  logic [3:0]      mask_q;
  logic [3:0]      visited_q;
  logic [3:0]      remain;
  logic            pick_found;
  logic [1:0]      pick_idx;
  logic [RW-1:0]   retry_q;
  logic [WW-1:0]   wait_q;
  logic [7:0]      cap_hum;
  logic [7:0]      cap_temp;
  logic [7:0]      hum_mem  [4];
  logic [7:0]      temp_mem [4];
  logic [3:0]      valid_q;

  // True on the tick that completes an n-millisecond wait.
  function automatic logic wait_reached(input logic [WW-1:0] cnt, input int unsigned n);
    return (32'(cnt) + 32'd1) >= n;
  endfunction

  assign ms_tick = (presc_cnt == PW'(TICK_DIV - 1));

  // Free-running millisecond prescaler.
  // NOTE: sequential state is written with non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     presc_cnt <= '0;
    else if (ms_tick) presc_cnt <= '0;
    else              presc_cnt <= presc_cnt + PW'(1);
  end

  assign period_eff  = (auto_period_ms == 16'd0) ? 16'd1 : auto_period_ms;
  assign auto_expire = auto_en && ms_tick && (auto_cnt >= period_eff - 16'd1);

  // Periodic round timer: counts ticks while enabled and reloads on expiry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          auto_cnt <= '0;
    else if (!auto_en)     auto_cnt <= '0;
    else if (auto_expire)  auto_cnt <= '0;
    else if (ms_tick)      auto_cnt <= auto_cnt + 16'd1;
  end

  assign start_req = sw_req || auto_expire || pending_q;
  assign remain    = mask_q & ~visited_q;

  // Lowest channel of the latched mask not yet visited this round.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (remain[i]) begin
        pick_found = 1'b1;
        pick_idx   = 2'(i);
      end
    end
  end

  // Round sequencer with its registered outputs and the per-channel result store.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      eng_start  <= 1'b0;
      ch_sel     <= 2'd0;
      busy       <= 1'b0;
      round_done <= 1'b0;
      err_mask   <= 4'd0;
      pending_q  <= 1'b0;
      mask_q     <= 4'd0;
      visited_q  <= 4'd0;
      retry_q    <= '0;
      wait_q     <= '0;
      cap_hum    <= 8'd0;
      cap_temp   <= 8'd0;
      valid_q    <= 4'd0;
      // NOTE: the result store is only four entries and must read back as zero
      // after reset, so it is cleared here rather than left uninitialised.
      for (int i = 0; i < 4; i++) begin
        hum_mem[i]  <= 8'd0;
        temp_mem[i] <= 8'd0;
      end
    end else begin
      eng_start  <= 1'b0;
      round_done <= 1'b0;

      // One request can be queued behind a running round; further ones collapse into it.
      if (state_q != IDLE && sw_req) pending_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (start_req) begin
            mask_q    <= ch_mask;
            visited_q <= 4'd0;
            err_mask  <= 4'd0;
            busy      <= 1'b1;
            pending_q <= 1'b0;
            state_q   <= PICK;
          end
        end

        PICK: begin
          if (pick_found) begin
            ch_sel              <= pick_idx;
            visited_q[pick_idx] <= 1'b1;
            retry_q             <= '0;
            wait_q              <= '0;
            state_q             <= SETTLE;
          end else begin
            state_q <= FINISH;
          end
        end

        SETTLE: begin
          if (ms_tick) begin
            if (wait_reached(wait_q, SETTLE_MS)) begin
              wait_q    <= '0;
              eng_start <= 1'b1;
              state_q   <= START;
            end else begin
              wait_q <= wait_q + WW'(1);
            end
          end
        end

        START: begin
          wait_q  <= '0;
          state_q <= WAIT_DONE;
        end

        WAIT_DONE: begin
          if (eng_done && eng_chk_ok) begin
            cap_hum  <= eng_hum;
            cap_temp <= eng_temp;
            state_q  <= STORE;
          end else if (eng_done || (ms_tick && wait_reached(wait_q, TIMEOUT_MS))) begin
            wait_q <= '0;
            if (32'(retry_q) < MAX_RETRY) begin
              retry_q <= retry_q + RW'(1);
              state_q <= RETRY_WAIT;
            end else begin
              valid_q[ch_sel]  <= 1'b0;
              err_mask[ch_sel] <= 1'b1;
              state_q          <= PICK;
            end
          end else if (ms_tick) begin
            wait_q <= wait_q + WW'(1);
          end
        end

        STORE: begin
          hum_mem[ch_sel]  <= cap_hum;
          temp_mem[ch_sel] <= cap_temp;
          valid_q[ch_sel]  <= 1'b1;
          state_q          <= PICK;
        end

        RETRY_WAIT: begin
          if (ms_tick) begin
            if (wait_reached(wait_q, RETRY_MS)) begin
              wait_q    <= '0;
              eng_start <= 1'b1;
              state_q   <= START;
            end else begin
              wait_q <= wait_q + WW'(1);
            end
          end
        end

        FINISH: begin
          round_done <= 1'b1;
          busy       <= 1'b0;
          state_q    <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_hum   = hum_mem[rd_ch];
  assign rd_temp  = temp_mem[rd_ch];
  assign rd_valid = valid_q[rd_ch];

endmodule

// File: tb/tb_dht11_read_scheduler.sv
// Randomised bench for dht11_read_scheduler. The bench plays the read engine,
// plans every attempt of a round up front from the channel mask and retry
// rules, and predicts event cycles from the state sequence durations.
module tb_dht11_read_scheduler;

  localparam int unsigned SETTLE_MS  = 1;
  localparam int unsigned TIMEOUT_MS = 5;
  localparam int unsigned RETRY_MS   = 3;
  localparam int unsigned MAX_RETRY  = 2;

  typedef enum int {OK_RSP, BAD_RSP, NO_RSP} rsp_e;
  typedef struct {
    rsp_e       kind;
    logic [7:0] hum;
    logic [7:0] temp;
    int         ch;
    bit         last;
  } attempt_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sw_req = 1'b0;
  logic        auto_en = 1'b0;
  logic [15:0] auto_period_ms = 16'd20;
  logic [3:0]  ch_mask = 4'd0;
  logic        eng_start;
  logic        eng_done = 1'b0;
  logic        eng_chk_ok = 1'b0;
  logic [7:0]  eng_hum = 8'd0;
  logic [7:0]  eng_temp = 8'd0;
  logic [1:0]  ch_sel;
  logic [1:0]  rd_ch = 2'd0;
  logic [7:0]  rd_hum;
  logic [7:0]  rd_temp;
  logic        rd_valid;
  logic        busy;
  logic        round_done;
  logic [3:0]  err_mask;

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;

  // Reference result store
  logic [7:0]  m_hum   [4];
  logic [7:0]  m_temp  [4];
  bit          m_valid [4];
  attempt_t    forced_q[$];

  dht11_read_scheduler #(
    .CLK_FREQ_HZ(1000), .SETTLE_MS(SETTLE_MS), .TIMEOUT_MS(TIMEOUT_MS),
    .RETRY_MS(RETRY_MS), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sw_req(sw_req), .auto_en(auto_en),
    .auto_period_ms(auto_period_ms), .ch_mask(ch_mask), .eng_start(eng_start),
    .eng_done(eng_done), .eng_chk_ok(eng_chk_ok), .eng_hum(eng_hum),
    .eng_temp(eng_temp), .ch_sel(ch_sel), .rd_ch(rd_ch), .rd_hum(rd_hum),
    .rd_temp(rd_temp), .rd_valid(rd_valid), .busy(busy),
    .round_done(round_done), .err_mask(err_mask)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic attempt_t mk(input rsp_e k, input int h, input int t);
    attempt_t a;
    a.kind = k; a.hum = 8'(h); a.temp = 8'(t); a.ch = 0; a.last = 1'b0;
    return a;
  endfunction

  function automatic attempt_t next_attempt();
    int r;
    if (forced_q.size() > 0) return forced_q.pop_front();
    r = int'($urandom_range(0, 3));
    if (r < 2)       return mk(OK_RSP,  int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    else if (r == 2) return mk(BAD_RSP, 0, 0);
    else             return mk(NO_RSP,  0, 0);
  endfunction

  task automatic check_store();
    for (int ch = 0; ch < 4; ch++) begin
      rd_ch = 2'(ch);
      #1;
      check($sformatf("rd_hum[%0d]", ch),   rd_hum,   m_hum[ch]);
      check($sformatf("rd_temp[%0d]", ch),  rd_temp,  m_temp[ch]);
      check($sformatf("rd_valid[%0d]", ch), rd_valid, m_valid[ch]);
    end
  endtask

  // One software-triggered round; do_pending adds three sw_req pulses while busy.
  task automatic run_round(input logic [3:0] mask, input bit do_pending);
    attempt_t plan[$];
    attempt_t a, cur;
    logic [3:0] exp_err;
    int r, exp_cyc, done_at, f, pick, n_starts, n_planned, rd_cyc, cnt;
    bit finished, got_ok;

    exp_err = 4'd0;
    for (int ch = 0; ch < 4; ch++) begin
      if (mask[ch]) begin
        got_ok = 1'b0;
        for (int k = 0; k <= int'(MAX_RETRY) && !got_ok; k++) begin
          a = next_attempt();
          a.ch = ch;
          got_ok = (a.kind == OK_RSP);
          a.last = got_ok || (k == int'(MAX_RETRY));
          plan.push_back(a);
          if (got_ok) begin
            m_hum[ch] = a.hum; m_temp[ch] = a.temp; m_valid[ch] = 1'b1;
          end
        end
        if (!got_ok) begin
          exp_err[ch] = 1'b1;
          m_valid[ch] = 1'b0;
        end
      end
    end

    n_planned = plan.size(); n_starts = 0; done_at = -1; finished = 1'b0; rd_cyc = 0;
    ch_mask = mask; sw_req = 1'b1; r = cyc;
    exp_cyc = (n_planned > 0) ? r + 2 + int'(SETTLE_MS) : r + 3;
    for (int k = 0; k < 600 && !finished; k++) begin
      @(posedge clk); #1;
      sw_req = 1'b0; eng_done = 1'b0; eng_chk_ok = 1'b0;
      if (cyc == r + 1) ch_mask = do_pending ? 4'd0 : 4'($urandom);
      if (do_pending && (cyc == r + 2 || cyc == r + 4 || cyc == r + 6)) sw_req = 1'b1;
      if (eng_start) begin
        n_starts++;
        check("start_cycle", cyc, exp_cyc);
        if (plan.size() == 0) begin
          check("unplanned_start", eng_start, 0);
        end else begin
          cur = plan.pop_front();
          check("start_ch", ch_sel, cur.ch);
          done_at = -1;
          if (cur.kind == NO_RSP) begin
            f = cyc + int'(TIMEOUT_MS);
          end else begin
            done_at = cyc + int'($urandom_range(1, TIMEOUT_MS));
            f = done_at;
          end
          if (cur.kind != OK_RSP && !cur.last) begin
            exp_cyc = f + 1 + int'(RETRY_MS);
          end else begin
            pick    = (cur.kind == OK_RSP) ? f + 2 : f + 1;
            exp_cyc = (plan.size() > 0) ? pick + 1 + int'(SETTLE_MS) : pick + 2;
          end
        end
      end
      if (cyc == done_at) begin
        eng_done   = 1'b1;
        eng_chk_ok = (cur.kind == OK_RSP);
        eng_hum    = (cur.kind == OK_RSP) ? cur.hum  : 8'($urandom);
        eng_temp   = (cur.kind == OK_RSP) ? cur.temp : 8'($urandom);
      end
      if (round_done) begin
        finished = 1'b1;
        rd_cyc   = cyc;
        check("done_cycle", cyc, exp_cyc);
        check("busy_low_at_done", busy, 0);
        check("err_mask", err_mask, exp_err);
        check("start_count", n_starts, n_planned);
      end
    end
    check("round_finished", finished, 1);

    if (do_pending && finished) begin
      @(posedge clk); #1;
      check("pending_busy", busy, 1);
      finished = 1'b0;
      for (int k = 0; k < 20 && !finished; k++) begin
        @(posedge clk); #1;
        if (round_done) begin
          finished = 1'b1;
          check("pending_done_cycle", cyc, rd_cyc + 3);
        end
      end
      check("pending_finished", finished, 1);
      cnt = 0;
      repeat (12) begin
        @(posedge clk); #1;
        if (round_done || busy) cnt++;
      end
      check("no_third_round", cnt, 0);
      check("pending_err_mask", err_mask, 0);
    end
    check_store();
  endtask

  task automatic auto_test();
    int a, cnt, last;
    int t[$];
    ch_mask = 4'd0; auto_period_ms = 16'd20; auto_en = 1'b1; a = cyc;
    for (int k = 0; k < 80 && t.size() < 3; k++) begin
      @(posedge clk); #1;
      if (round_done) t.push_back(cyc);
    end
    check("auto_rounds", t.size(), 3);
    if (t.size() == 3) begin
      check("auto_first", t[0], a + 22);
      check("auto_gap1", t[1] - t[0], 20);
      check("auto_gap2", t[2] - t[1], 20);
    end
    // Software request in the very cycle the timer expires.
    for (int k = 0; k < 40 && cyc < a + 79; k++) begin @(posedge clk); #1; end
    sw_req = 1'b1;
    cnt = 0; last = 0;
    repeat (18) begin
      @(posedge clk); #1;
      sw_req = 1'b0;
      if (round_done) begin cnt++; last = cyc; end
    end
    check("merged_round_count", cnt, 1);
    check("merged_round_cycle", last, a + 82);
    // Period 0 behaves as 1: back-to-back rounds every 3 cycles.
    auto_period_ms = 16'd0;
    t.delete();
    for (int k = 0; k < 40 && t.size() < 4; k++) begin
      @(posedge clk); #1;
      if (round_done) t.push_back(cyc);
    end
    check("auto_p0_rounds", t.size(), 4);
    if (t.size() == 4) begin
      check("auto_p0_gap1", t[2] - t[1], 3);
      check("auto_p0_gap2", t[3] - t[2], 3);
    end
    auto_en = 1'b0; auto_period_ms = 16'd20;
    repeat (5) @(posedge clk);
    #1;
    cnt = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (round_done || busy) cnt++;
    end
    check("auto_off_quiet", cnt, 0);
  endtask

  task automatic reset_test();
    bit seen;
    int cnt;
    ch_mask = 4'b0100; sw_req = 1'b1;
    @(posedge clk); #1;
    sw_req = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clk); #1;
      if (eng_start) seen = 1'b1;
    end
    check("rst_start_seen", seen, 1);
    @(posedge clk); #1;
    check("rst_pre_busy", busy, 1);
    check("rst_pre_ch_sel", ch_sel, 2);
    #2 reset_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_ch_sel", ch_sel, 0);
    check("rst_eng_start", eng_start, 0);
    check("rst_round_done", round_done, 0);
    check("rst_err_mask", err_mask, 0);
    for (int ch = 0; ch < 4; ch++) begin
      m_hum[ch] = 8'd0; m_temp[ch] = 8'd0; m_valid[ch] = 1'b0;
    end
    check_store();
    @(posedge clk); #3 reset_n = 1'b1;
    @(posedge clk); #1;
    eng_done = 1'b1; eng_chk_ok = 1'b1; eng_hum = 8'd77; eng_temp = 8'd33;
    cnt = 0;
    repeat (20) begin
      @(posedge clk); #1;
      eng_done = 1'b0; eng_chk_ok = 1'b0;
      if (eng_start || busy || round_done) cnt++;
    end
    check("rst_quiet_after_release", cnt, 0);
    check_store();
  endtask

  initial begin
    for (int ch = 0; ch < 4; ch++) begin
      m_hum[ch] = 8'd0; m_temp[ch] = 8'd0; m_valid[ch] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("init_busy", busy, 0);
    check("init_eng_start", eng_start, 0);
    check("init_round_done", round_done, 0);
    check("init_err_mask", err_mask, 0);
    check("init_ch_sel", ch_sel, 0);
    check_store();
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Two channels, both read cleanly.
    forced_q.push_back(mk(OK_RSP, 45, 23));
    forced_q.push_back(mk(OK_RSP, 50, 25));
    run_round(4'b0101, 1'b0);
    // Bad checksum, then a good read.
    forced_q.push_back(mk(BAD_RSP, 0, 0));
    forced_q.push_back(mk(OK_RSP, 60, 21));
    run_round(4'b0001, 1'b0);
    // Engine silent on every attempt: retries exhausted.
    forced_q.push_back(mk(NO_RSP, 0, 0));
    forced_q.push_back(mk(NO_RSP, 0, 0));
    forced_q.push_back(mk(NO_RSP, 0, 0));
    run_round(4'b0001, 1'b0);
    // Requests queued while busy collapse into one extra round.
    run_round(4'($urandom) | 4'b0001, 1'b1);

    for (int i = 0; i < 12; i++) begin
      run_round(4'($urandom), 1'b0);
      repeat (int'($urandom_range(1, 4))) @(posedge clk);
      #1;
    end

    // Stray engine completion while idle must not touch the store.
    eng_done = 1'b1; eng_chk_ok = 1'b1; eng_hum = 8'd99; eng_temp = 8'd98;
    @(posedge clk); #1;
    eng_done = 1'b0; eng_chk_ok = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_stray_busy", busy, 0);
    check_store();

    auto_test();
    reset_test();
    run_round(4'b0100, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dht11_read_scheduler.md
DHT11_READ_SCHEDULER -- requirements
Module: dht11_read_scheduler

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 100_000_000, system clock frequency used to derive a 1 ms tick.
REQ-002 SHALL have parameter SETTLE_MS, default 1, delay after changing ch_sel before eng_start.
REQ-003 SHALL have parameter TIMEOUT_MS, default 50, maximum wait for eng_done after eng_start.
REQ-004 SHALL have parameter RETRY_MS, default 1000, gap before re-reading a failed channel.
REQ-005 SHALL have parameter MAX_RETRY, default 2, number of re-reads after the first failed attempt.
REQ-006 SHALL have ports, one per line:
- clk  in  1  system clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- sw_req  in  1  one-cycle pulse requesting one scan round.
- auto_en  in  1  enables periodic rounds.
- auto_period_ms  in  16  interval between periodic round starts; 0 is treated as 1.
- ch_mask  in  4  enabled sensor channels; sampled at round start.
- eng_start  out  1  one-cycle start pulse to the single-wire read engine.
- eng_done  in  1  one-cycle pulse: engine finished.
- eng_chk_ok  in  1  checksum valid; qualified by eng_done.
- eng_hum  in  8  humidity integer part; qualified by eng_done.
- eng_temp  in  8  temperature integer part; qualified by eng_done.
- ch_sel  out  2  channel currently routed to the engine.
- rd_ch  in  2  result read address.
- rd_hum  out  8  stored humidity of rd_ch; combinational read.
- rd_temp  out  8  stored temperature of rd_ch; combinational read.
- rd_valid  out  1  rd_ch holds a result from its most recent scan.
- busy  out  1  round in progress.
- round_done  out  1  one-cycle pulse at round end.
- err_mask  out  4  channels that exhausted retries in the last round.

Function
REQ-007 SHALL generate ms_tick, one cycle every CLK_FREQ_HZ/1000 clocks, free-running from reset.
REQ-008 SHALL have the states IDLE, PICK, SETTLE, START, WAIT_DONE, STORE, RETRY_WAIT, FINISH.
REQ-009 In IDLE, a round SHALL start on sw_req, on the auto timer expiring, or on a pending request: latch ch_mask, clear err_mask, set busy=1, go to PICK next cycle.
- sw_req and auto expiry in the same cycle SHALL start one round.
REQ-010 sw_req while busy SHALL set a single pending flag; additional requests SHALL be dropped; the pending round SHALL start on the cycle after FINISH.
REQ-011 The auto timer SHALL count ms_ticks while auto_en=1, expire at auto_period_ms, and reload on expiry; an expiry while busy SHALL be dropped; auto_en=0 SHALL clear the timer.
REQ-012 PICK SHALL choose the lowest unvisited channel set in the latched mask, in ascending order 0..3, load ch_sel, zero the retry count, and go to SETTLE; if none remain it SHALL go to FINISH.
REQ-013 SETTLE SHALL wait SETTLE_MS ms_ticks, then go to START.
REQ-014 START SHALL assert eng_start for exactly one cycle, then go to WAIT_DONE.
REQ-015 WAIT_DONE behaviour:
- eng_done with eng_chk_ok=1 SHALL go to STORE.
- eng_done with eng_chk_ok=0, or TIMEOUT_MS ms_ticks without eng_done, SHALL be a failure.
REQ-016 STORE SHALL write eng_hum and eng_temp to the ch_sel entry, set its valid bit, then go to PICK; the data SHALL be visible on rd_* the cycle after the write.
REQ-017 On failure with retry count < MAX_RETRY: SHALL increment the count and go to RETRY_WAIT (RETRY_MS ms_ticks), then START.
REQ-018 On failure with retry count = MAX_RETRY: SHALL clear that channel's valid bit, set its err_mask bit, and go to PICK.
REQ-019 eng_done outside WAIT_DONE SHALL be ignored.
REQ-020 FINISH SHALL pulse round_done for one cycle, drop busy in the same cycle, and return to IDLE.
- Latched mask of 0: round_done SHALL pulse 3 cycles after the start request (IDLE->PICK->FINISH).
REQ-021 ch_mask changes during a round SHALL not affect it; unselected channels keep their stored entries.

Reset
REQ-022 reset_n=0 SHALL, asynchronously:
- set state to IDLE;
- set eng_start=0, ch_sel=0, busy=0, round_done=0, err_mask=0;
- clear all stored data and valid bits, so rd_hum=0, rd_temp=0, rd_valid=0;
- clear the pending flag, auto timer, retry count and ms prescaler.
REQ-023 Reset asserted mid-round SHALL abort it; no round SHALL start after release until a new trigger arrives.

Verification (sim with CLK_FREQ_HZ=1000, i.e. 1 tick per clock; SETTLE_MS=1, TIMEOUT_MS=5, RETRY_MS=3, MAX_RETRY=2)
REQ-024 ch_mask=4'b0101, sw_req, engine returns ok with hum=45/temp=23, then 50/25 -> eng_start seen with ch_sel=0 then 2; rd_ch=2 gives 50/25, valid=1; err_mask=0; one round_done.
REQ-025 ch_mask=4'b0001, engine never sends eng_done -> exactly 3 eng_start pulses, each 5 cycles after the previous WAIT_DONE entry plus a 3-cycle retry gap; err_mask=4'b0001; rd_valid=0 for ch 0.
REQ-026 First attempt eng_chk_ok=0, second ok with hum=60 -> 2 starts; ch 0 stores 60, valid=1, err_mask=0.
REQ-027 sw_req pulsed 3 times during a busy round -> exactly one extra round, starting the cycle after round_done.
REQ-028 auto_en=1, auto_period_ms=20, ch_mask=0 -> round_done every 20 cycles; sw_req in the same cycle as expiry -> a single round.
REQ-029 reset_n low during WAIT_DONE, then stray eng_done after release -> all outputs 0, no store, no eng_start until the next sw_req.
